display_source_scheduler: RTL and testbench

- Sequencer that drives the select input of the display source multiplexer. It chooses between the decoded-frequency source (sm=1) and the 10-bit counter source (sm=0).
- Alternates the two sources automatically on a dwell timer, or on user request in manual mode.
- Inserts a blanking interval on every switch so the display never shows a half-updated value.
- Sits between the user-input logic and the display mux/driver; all outputs are registered on clkm.

---
 rtl/disp_sched_pkg.sv | 25 ++
 rtl/disp_interval_counter.sv | 33 +++
 rtl/display_source_scheduler.sv | 110 +++++++++++
 tb/tb_display_source_scheduler.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/disp_sched_pkg.sv
// Shared encodings for the display source scheduler: FSM states, source select
// values and the registered output bundle.
package disp_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_SHOW_FREQ = 2'b01,
        ST_BLANK     = 2'b10,
        ST_SHOW_CNT  = 2'b11
    } state_t;

    localparam logic SRC_FREQ = 1'b1;
    localparam logic SRC_CNT  = 1'b0;

    typedef struct packed {
        logic sm;
        logic blank;
        logic switch_stb;
    } disp_out_t;

    function automatic state_t show_state(input logic src);
        return (src == SRC_FREQ) ? ST_SHOW_FREQ : ST_SHOW_CNT;
    endfunction

endpackage

// File: rtl/disp_interval_counter.sv
// Shared interval counter: clear, pause and terminal-count compare against
// either the dwell or the blank limit.
module disp_interval_counter #(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 26
) (
    input  logic clkm,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    input  logic sel_blank,
    output logic tc
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    // A zero blank length never selects this limit; keep the constant in range.
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clkm or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + CNT_W'(1);
    end

    assign tc = (cnt == (sel_blank ? BLANK_LAST : DWELL_LAST));

endmodule

// File: rtl/display_source_scheduler.sv
// Display source sequencer: alternates DecoFre/Conta10 with a blanking gap.
// Define BTN_SYNC_EN to synchronize btn_next and treat only its rising edge as a request.
module display_source_scheduler
    import disp_sched_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int BLANK_CYCLES = 1000,
    parameter int CNT_W        = 26
) (
    input  logic       clkm,
    input  logic       reset,
    input  logic       en,
    input  logic       auto_mode,
    input  logic       btn_next,
    input  logic       hold,
    output logic       sm,
    output logic       blank,
    output logic       switch_stb,
    output logic [1:0] state
);

    state_t    st, st_nxt;
    logic      nxt_src, nxt_src_d;
    disp_out_t o_q, o_d;
    logic      btn_req, tc, in_show, exit_show;

`ifdef BTN_SYNC_EN
    // Two sync flops plus one history flop for the rising-edge detect.
    logic [2:0] btn_pipe;

    always_ff @(posedge clkm or posedge reset) begin
        if (reset)
            btn_pipe <= '0;
        else
            btn_pipe <= {btn_pipe[1:0], btn_next};
    end

    assign btn_req = btn_pipe[1] & ~btn_pipe[2];
`else
    assign btn_req = btn_next;
`endif

    assign in_show   = (st == ST_SHOW_FREQ) || (st == ST_SHOW_CNT);
    assign exit_show = !hold && (auto_mode ? tc : btn_req);

    disp_interval_counter #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (CNT_W)
    ) u_cnt (
        .clkm      (clkm),
        .reset     (reset),
        .clr       ((st_nxt != st) || (st == ST_IDLE)),
        .inc       ((st == ST_BLANK) || (in_show && !hold)),
        .sel_blank (st == ST_BLANK),
        .tc        (tc)
    );

    always_ff @(posedge clkm or posedge reset) begin
        if (reset) begin
            st      <= ST_IDLE;
            nxt_src <= SRC_FREQ;
            o_q     <= '{sm: SRC_FREQ, blank: 1'b1, switch_stb: 1'b0};
        end else begin
            st      <= st_nxt;
            nxt_src <= nxt_src_d;
            o_q     <= o_d;
        end
    end

    always_comb begin
        st_nxt    = st;
        nxt_src_d = nxt_src;
        if (!en) begin
            st_nxt = ST_IDLE;
        end else begin
            case (st)
                ST_IDLE: st_nxt = ST_SHOW_FREQ;
                ST_SHOW_FREQ, ST_SHOW_CNT: begin
                    if (exit_show) begin
                        nxt_src_d = (st == ST_SHOW_FREQ) ? SRC_CNT : SRC_FREQ;
                        st_nxt    = (BLANK_CYCLES == 0) ? show_state(nxt_src_d) : ST_BLANK;
                    end
                end
                ST_BLANK: if (tc) st_nxt = show_state(nxt_src);
                default: st_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are computed from the upcoming state so they register alongside it.
    always_comb begin
        o_d = '{sm: o_q.sm, blank: 1'b1, switch_stb: 1'b0};
        case (st_nxt)
            ST_SHOW_FREQ, ST_SHOW_CNT: begin
                o_d.blank      = 1'b0;
                o_d.sm         = (st_nxt == ST_SHOW_FREQ) ? SRC_FREQ : SRC_CNT;
                o_d.switch_stb = (st_nxt != st);
            end
            ST_IDLE: o_d.sm = SRC_FREQ;
            default: ;
        endcase
    end

    assign sm         = o_q.sm;
    assign blank      = o_q.blank;
    assign switch_stb = o_q.switch_stb;
    assign state      = st;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Directed bench: one instance with a 2-cycle blank and one with blanking disabled,
// both driven by the same inputs; dwell is 8 cycles.
module tb_display_source_scheduler;

`ifdef BTN_SYNC_EN
    localparam int BTN_LAT  = 3;
    localparam int HELD_TOG = 1;
`else
    localparam int BTN_LAT  = 1;
    localparam int HELD_TOG = 7;
`endif

    logic clkm, reset, en, auto_mode, btn_next, hold;
    logic sm2, blank2, stb2, sm0, blank0, stb0;
    logic [1:0] st2, st0;
    int checks = 0;
    int errors = 0;

    display_source_scheduler #(.DWELL_CYCLES(8), .BLANK_CYCLES(2), .CNT_W(4)) u2 (
        .clkm(clkm), .reset(reset), .en(en), .auto_mode(auto_mode), .btn_next(btn_next),
        .hold(hold), .sm(sm2), .blank(blank2), .switch_stb(stb2), .state(st2));

    display_source_scheduler #(.DWELL_CYCLES(8), .BLANK_CYCLES(0), .CNT_W(4)) u0 (
        .clkm(clkm), .reset(reset), .en(en), .auto_mode(auto_mode), .btn_next(btn_next),
        .hold(hold), .sm(sm0), .blank(blank0), .switch_stb(stb0), .state(st0));

    initial clkm = 1'b0;
    always #5 clkm = ~clkm;

    task automatic tick();
        @(posedge clkm);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  p, per, n_stb, n_blank, first_blank, stb_at;
        logic src, exp_blank, ok, found;

        reset = 1'b1; en = 1'b1; auto_mode = 1'b1; btn_next = 1'b0; hold = 1'b0;
        repeat (2) tick();
        check("rst_sm", sm2, 1);
        check("rst_blank", blank2, 1);
        check("rst_state", st2, 0);
        check("rst_stb", stb2, 0);
        check("rst_state_b0", st0, 0);
        reset = 1'b0;

        // Auto alternation: period 10 with blanking, period 8 without.
        for (int k = 1; k <= 40; k++) begin
            tick();
            p = (k - 1) % 10; per = (k - 1) / 10;
            src = (per % 2 == 0); exp_blank = (p >= 8);
            check("auto_sm", sm2, src);
            check("auto_blank", blank2, exp_blank);
            check("auto_stb", stb2, (p == 0));
            check("auto_state", st2, exp_blank ? 2 : (src ? 1 : 3));
            p = (k - 1) % 8;
            src = (((k - 1) / 8) % 2 == 0);
            check("b0_sm", sm0, src);
            check("b0_blank", blank0, 0);
            check("b0_stb", stb0, (p == 0));
            check("b0_state", st0, src ? 1 : 3);
        end

        // Hold for 5 cycles stretches the FREQ show period to 13 cycles.
        tick();
        check("hold_start_stb", stb2, 1);
        check("hold_start_sm", sm2, 1);
        ok = 1'b1;
        for (int k = 42; k <= 53; k++) begin
            tick();
            hold = (k >= 43 && k <= 47);
            ok &= (blank2 == 1'b0) && (sm2 == 1'b1) && (stb2 == 1'b0);
        end
        check("hold_show_steady", ok, 1);
        tick();
        check("hold_show_len", blank2, 1);
        check("hold_blank_state", st2, 2);
        tick();
        check("hold_blank2", st2, 2);
        tick();
        check("hold_after_sm", sm2, 0);
        check("hold_after_stb", stb2, 1);
        check("hold_after_state", st2, 3);

        // Manual mode: idle cycles never switch.
        auto_mode = 1'b0;
        n_stb = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (stb2) n_stb++;
        end
        check("man_idle_stb", n_stb, 0);
        check("man_idle_sm", sm2, 0);
        check("man_idle_state", st2, 3);

        // One press, then a second press that lands in the blank and is ignored.
        btn_next = 1'b1;
        n_stb = 0; n_blank = 0; first_blank = 0; stb_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            btn_next = (i == 2);
            if (blank2) begin
                n_blank++;
                if (first_blank == 0) first_blank = i;
            end
            if (stb2) begin
                n_stb++;
                stb_at = i;
            end
        end
        check("man_btn_lat", first_blank, BTN_LAT);
        check("man_blank_len", n_blank, 2);
        check("man_toggles", n_stb, 1);
        check("man_stb_at", stb_at, BTN_LAT + 2);
        check("man_sm", sm2, 1);
        check("man_state", st2, 1);

        // Drop en during the blank that follows SHOW_CNT.
        auto_mode = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = (st2 == 2'd3);
        end
        check("en_wait_cnt", found, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = blank2;
        end
        check("en_wait_blank", found, 1);
        check("en_blank_sm", sm2, 0);
        en = 1'b0;
        tick();
        check("en_off_state", st2, 0);
        check("en_off_sm", sm2, 1);
        check("en_off_blank", blank2, 1);
        check("en_off_stb", stb2, 0);
        tick();
        check("en_off_stay", st2, 0);
        en = 1'b1;
        tick();
        check("en_on_state", st2, 1);
        check("en_on_stb", stb2, 1);
        check("en_on_blank", blank2, 0);
        tick();
        check("en_on_stb_once", stb2, 0);

        // Button held high for 20 cycles in manual mode.
        auto_mode = 1'b0;
        btn_next = 1'b1;
        n_stb = 0;
        for (int i = 1; i <= 26; i++) begin
            tick();
            if (i == 20) btn_next = 1'b0;
            if (stb2) n_stb++;
        end
        check("held_toggles", n_stb, HELD_TOG);
        check("held_sm", sm2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
